four_12_12_st2_error_tx: RTL

//  Transmit end of the stage-2 error stream. Buffers per-sample error values from the

---
 rtl/four_12_12_st2_error_tx.sv | 119 +++++++++++
 1 files changed

// File: rtl/four_12_12_st2_error_tx.sv
// Stage-2 error stream transmitter: buffers subtractor error words in a FIFO and
// drives them to the error-FIFO controller as framed bursts under ready backpressure.
module four_12_12_st2_error_tx #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4,
   parameter int WIDTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  error_in,
   input  logic              error_in_vld,
   output logic              error_in_rdy,
   input  logic [3:0]        error_tap_length,
   input  logic              flush,
   output logic [WIDTH-1:0]  stage_2_error,
   output logic              stage_2_error_vld,
   output logic              stage_2_error_fst,
   input  logic              stage_2_error_rdy,
   output logic [ADDR_W:0]   fifo_level,
   output logic              frame_done,
   output logic [7:0]        frames_sent
);

   // IDLE: no frame in progress (load_idx==0); MID: part-way through a frame
   typedef enum logic {IDLE, MID} frame_state_t;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [3:0]        load_idx;
   logic [3:0]        len_lat;
   logic              last_q;
   frame_state_t      frame_state;

   logic              wr_en;
   logic              rd_en;
   logic              accept;
   logic              load;
   logic              starting;
   logic [3:0]        eff_len;
   logic              is_last;

   // Ready is a pure function of the registered level, so a full FIFO stays
   // not-ready even in a cycle where a read frees an entry.
   assign error_in_rdy = ~fifo_level[ADDR_W];
   assign wr_en        = error_in_vld & error_in_rdy & ~flush;
   assign accept       = stage_2_error_vld & stage_2_error_rdy;
   assign load         = (fifo_level != '0) & (~stage_2_error_vld | stage_2_error_rdy);
   assign rd_en        = load & ~flush;
   assign starting     = (frame_state == IDLE);
   assign eff_len      = starting ? error_tap_length : len_lat;
   assign is_last      = (load_idx == eff_len);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= error_in;
      end
   end

   // FIFO pointers, output register and framing all advance together; framing is
   // decided when a beat is loaded into the output register, not when it is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fifo_level        <= '0;
         stage_2_error     <= '0;
         stage_2_error_vld <= 1'b0;
         stage_2_error_fst <= 1'b0;
         last_q            <= 1'b0;
         load_idx          <= '0;
         len_lat           <= '0;
         frame_state       <= IDLE;
         frame_done        <= 1'b0;
         frames_sent       <= '0;
      end else if (flush) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fifo_level        <= '0;
         stage_2_error_vld <= 1'b0;
         stage_2_error_fst <= 1'b0;
         last_q            <= 1'b0;
         load_idx          <= '0;
         frame_state       <= IDLE;
         frame_done        <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fifo_level  <= fifo_level + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, rd_en};
         frame_done  <= accept & last_q;
         if (accept & last_q) begin
            frames_sent <= frames_sent + 8'd1;
         end
         if (load) begin
            stage_2_error     <= mem[rd_ptr];
            stage_2_error_vld <= 1'b1;
            stage_2_error_fst <= starting;
            last_q            <= is_last;
            if (starting) begin
               len_lat <= error_tap_length;
            end
            if (is_last) begin
               load_idx    <= '0;
               frame_state <= IDLE;
            end else begin
               load_idx    <= load_idx + 4'd1;
               frame_state <= MID;
            end
         end else if (accept) begin
            stage_2_error_vld <= 1'b0;
         end
      end
   end

endmodule
